// File: rtl/rgmii_tx_mux_pkg.sv
// Shared encodings for the RGMII transmit formatter: speed codes, formatter states,
// and normalisation of the requested speed (the unused code 2'b11 runs as 1000M).
package rgmii_tx_mux_pkg;

  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_10   = 2'b00;

  typedef enum logic [1:0] {
    S_GIG = 2'd0,
    S_LO  = 2'd1,
    S_HI  = 2'd2
  } state_t;

  function automatic logic [1:0] norm_spd(input logic [1:0] spd);
    case (spd)
      SPD_100: return SPD_100;
      SPD_10:  return SPD_10;
      default: return SPD_1000;
    endcase
  endfunction

endpackage

// File: rtl/rgmii_tx_mux.sv
// GMII-to-RGMII transmit formatter: registered rise/fall pairs appear one CLK after a byte is sampled.
// The byte source is throttled by TX_RDY: every cycle at 1000M, once per 2*DIV cycles at 100M/10M.
module rgmii_tx_mux
  import rgmii_tx_mux_pkg::*;
#(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] SPEED,
  input  logic       CLK_OE,
  input  logic [7:0] TXD_IN,
  input  logic       TX_EN,
  input  logic       TX_ER,
  output logic       TX_RDY,
  output logic       TXC_R,
  output logic       TXC_F,
  output logic [3:0] TXD_R,
  output logic [3:0] TXD_F,
  output logic       CTL_R,
  output logic       CTL_F
);

  localparam int CW = $clog2(DIV_10);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    spd_q, spd_d;
  logic          rst_q, rst_d;
  logic          start_q, start_d;
  logic [7:0]    byte_q, byte_d;
  logic          en_q, en_d;
  logic          er_q, er_d;
  logic          txc_r_q, txc_r_d;
  logic          txc_f_q, txc_f_d;
  logic [3:0]    txd_r_q, txd_r_d;
  logic [3:0]    txd_f_q, txd_f_d;
  logic          ctl_r_q, ctl_r_d;
  logic          ctl_f_q, ctl_f_d;
  logic [1:0]    req_spd;
  logic          last_cnt;
  logic          tx_rdy;

  function automatic int div_of(input logic [1:0] spd);
    return (spd == SPD_100) ? DIV_100 : DIV_10;
  endfunction

  assign req_spd  = norm_spd(SPEED);
  assign last_cnt = (int'(cnt_q) == div_of(spd_q) - 1);
  // rst_q marks the cycle right after a reset edge; start_q the first free-running cycle after it.
  assign tx_rdy   = !rst_q && ((state_q == S_GIG) || start_q ||
                               ((state_q == S_HI) && last_cnt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spd_d   = spd_q;
    rst_d   = 1'b0;
    start_d = rst_q;
    byte_d  = byte_q;
    en_d    = en_q;
    er_d    = er_q;
    txc_r_d = txc_r_q;
    txc_f_d = txc_f_q;
    txd_r_d = txd_r_q;
    txd_f_d = txd_f_q;
    ctl_r_d = ctl_r_q;
    ctl_f_d = ctl_f_q;

    if (!rst_q) begin
      if (tx_rdy) begin
        byte_d = TXD_IN;
        en_d   = TX_EN;
        er_d   = TX_ER;
        // Speed only changes on an idle byte, and governs that same byte.
        if (!TX_EN && !TX_ER) spd_d = req_spd;
        cnt_d   = '0;
        state_d = (spd_d == SPD_1000) ? S_GIG : S_LO;
      end else if (state_q != S_GIG) begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = (state_q == S_LO) ? S_HI : S_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      if (state_d == S_GIG) begin
        txd_r_d = byte_d[3:0];
        txd_f_d = byte_d[7:4];
        txc_r_d = CLK_OE;
        txc_f_d = 1'b0;
      end else begin
        txd_r_d = (state_d == S_LO) ? byte_d[3:0] : byte_d[7:4];
        txd_f_d = txd_r_d;
        txc_r_d = CLK_OE && (2 * int'(cnt_d) < div_of(spd_d));
        txc_f_d = CLK_OE && (2 * int'(cnt_d) + 1 < div_of(spd_d));
      end
      ctl_r_d = en_d;
      ctl_f_d = en_d ^ er_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= (req_spd == SPD_1000) ? S_GIG : S_LO;
      cnt_q   <= '0;
      spd_q   <= req_spd;
      rst_q   <= 1'b1;
      start_q <= 1'b0;
      byte_q  <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      txc_r_q <= 1'b0;
      txc_f_q <= 1'b0;
      txd_r_q <= '0;
      txd_f_q <= '0;
      ctl_r_q <= 1'b0;
      ctl_f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spd_q   <= spd_d;
      rst_q   <= rst_d;
      start_q <= start_d;
      byte_q  <= byte_d;
      en_q    <= en_d;
      er_q    <= er_d;
      txc_r_q <= txc_r_d;
      txc_f_q <= txc_f_d;
      txd_r_q <= txd_r_d;
      txd_f_q <= txd_f_d;
      ctl_r_q <= ctl_r_d;
      ctl_f_q <= ctl_f_d;
    end
  end

  assign TX_RDY = tx_rdy;
  assign TXC_R  = txc_r_q;
  assign TXC_F  = txc_f_q;
  assign TXD_R  = txd_r_q;
  assign TXD_F  = txd_f_q;
  assign CTL_R  = ctl_r_q;
  assign CTL_F  = ctl_f_q;

endmodule

// File: tb/tb_rgmii_tx_mux.sv
// Directed bench for rgmii_tx_mux (DIV_100=5, DIV_10=50): 1000M, error coding, deferred speed
// change, 100M nibble/TXC pattern, 10M CLK_OE gating, and reset mid-byte.
module tb_rgmii_tx_mux;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] SPEED;
  logic       CLK_OE;
  logic [7:0] TXD_IN;
  logic       TX_EN;
  logic       TX_ER;
  logic       TX_RDY;
  logic       TXC_R;
  logic       TXC_F;
  logic [3:0] TXD_R;
  logic [3:0] TXD_F;
  logic       CTL_R;
  logic       CTL_F;

  int errors = 0;
  int checks = 0;
  int n;
  logic [1:0] txc_exp [5];

  rgmii_tx_mux #(.DIV_100(5), .DIV_10(50)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SPEED  (SPEED),
    .CLK_OE (CLK_OE),
    .TXD_IN (TXD_IN),
    .TX_EN  (TX_EN),
    .TX_ER  (TX_ER),
    .TX_RDY (TX_RDY),
    .TXC_R  (TXC_R),
    .TXC_F  (TXC_F),
    .TXD_R  (TXD_R),
    .TXD_F  (TXD_F),
    .CTL_R  (CTL_R),
    .CTL_F  (CTL_F)
  );

  always #4 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] txc, input logic [3:0] r,
                         input logic [3:0] f, input logic [1:0] ctl, input logic rdy);
    chk({tag, ".txc"}, {30'd0, TXC_R, TXC_F}, {30'd0, txc});
    chk({tag, ".txd_r"}, {28'd0, TXD_R}, {28'd0, r});
    chk({tag, ".txd_f"}, {28'd0, TXD_F}, {28'd0, f});
    chk({tag, ".ctl"}, {30'd0, CTL_R, CTL_F}, {30'd0, ctl});
    chk({tag, ".rdy"}, {31'd0, TX_RDY}, {31'd0, rdy});
  endtask

  task automatic wait_rdy(input int max, output int cyc);
    cyc = 0;
    while (TX_RDY !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    txc_exp = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    RST = 1'b1; SPEED = 2'b10; CLK_OE = 1'b1;
    TXD_IN = 8'h00; TX_EN = 1'b0; TX_ER = 1'b0;
    tick();
    tick();
    chk_all("reset", 2'b00, 4'h0, 4'h0, 2'b00, 1'b0);
    RST = 1'b0;
    tick();
    chk("release_rdy", {31'd0, TX_RDY}, 32'd1);

    // 1000M data and error coding
    TXD_IN = 8'hA5; TX_EN = 1'b1; tick();
    chk_all("gig_a5", 2'b10, 4'h5, 4'hA, 2'b11, 1'b1);
    TXD_IN = 8'h7E; TX_ER = 1'b1; tick();
    chk_all("gig_err", 2'b10, 4'hE, 4'h7, 2'b10, 1'b1);
    TXD_IN = 8'h0F; TX_EN = 1'b0; tick();
    chk_all("gig_ext", 2'b10, 4'hF, 4'h0, 2'b01, 1'b1);

    // Speed request during a frame waits for the first idle byte
    SPEED = 2'b01; TXD_IN = 8'h11; TX_EN = 1'b1; TX_ER = 1'b0; tick();
    chk_all("defer1", 2'b10, 4'h1, 4'h1, 2'b11, 1'b1);
    TXD_IN = 8'h22; tick();
    chk_all("defer2", 2'b10, 4'h2, 4'h2, 2'b11, 1'b1);
    TXD_IN = 8'h00; TX_EN = 1'b0; tick();
    chk_all("to100", 2'b11, 4'h0, 4'h0, 2'b00, 1'b0);

    // 100M: ready once per 10 CLK, then byte 3C as nibbles with divided TXC
    TXD_IN = 8'h3C; TX_EN = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("rdy100", {31'd0, TX_RDY}, {31'd0, (i == 9)});
    end
    tick();
    for (int j = 0; j < 10; j++) begin
      chk_all("b100", txc_exp[j % 5], (j < 5) ? 4'hC : 4'h3, (j < 5) ? 4'hC : 4'h3,
              2'b11, (j == 9));
      if (j == 9) begin
        SPEED = 2'b00; TXD_IN = 8'h00; TX_EN = 1'b0;
      end
      tick();
    end

    // 10M: spacing, then CLK_OE gating mid-frame
    wait_rdy(200, n);
    chk("space10", n, 32'd99);
    TXD_IN = 8'h5A; TX_EN = 1'b1; tick();
    chk_all("b10_lo", 2'b11, 4'hA, 4'hA, 2'b11, 1'b0);
    repeat (10) tick();
    CLK_OE = 1'b0; tick();
    chk_all("oe_off", 2'b00, 4'hA, 4'hA, 2'b11, 1'b0);
    repeat (39) tick();
    chk_all("oe_off_hi", 2'b00, 4'h5, 4'h5, 2'b11, 1'b0);
    repeat (30) tick();
    CLK_OE = 1'b1; tick();
    chk("oe_on_low", {30'd0, TXC_R, TXC_F}, 32'd0);
    repeat (18) tick();
    chk_all("oe_hi_end", 2'b00, 4'h5, 4'h5, 2'b11, 1'b1);
    TXD_IN = 8'hC3; tick();
    chk_all("oe_rise", 2'b11, 4'h3, 4'h3, 2'b11, 1'b0);

    // Reset in the middle of a 10M byte
    repeat (5) tick();
    RST = 1'b1; tick();
    chk_all("rst_mid", 2'b00, 4'h0, 4'h0, 2'b00, 1'b0);
    RST = 1'b0; tick();
    chk_all("rst_rel", 2'b00, 4'h0, 4'h0, 2'b00, 1'b1);
    TXD_IN = 8'h96; tick();
    chk_all("post_rst", 2'b11, 4'h6, 4'h6, 2'b11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
